// File: rtl/nios_pio_sensor_scan.sv
// Conditioned sensor PIO: 2-flop sync, tick-based debounce, edge capture, occupancy count, irq.
// Optional build macro SENSOR_FULL_IRQ_EN adds a sticky full-event bit (STATUS[16]) and its mask (IRQMASK[16]).
module nios_pio_sensor_scan #(
    parameter int unsigned WIDTH          = 8,
    parameter logic [15:0] DIV_RESET      = 16'd50000,
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0]      sync1_q, sync2_q;
    logic [WIDTH-1:0]      stable_q, stable_d;
    logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      edge_q, edge_d;
    logic [WIDTH-1:0]      irqmask_q, irqmask_d;
    logic [15:0]           div_q, div_d;
    logic [15:0]           presc_q, presc_d;
    logic [4:0]            count_q, count_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  irq_q, irq_d;
    logic                  full_evt_q, full_evt_d;
    logic                  full_irq_en_q, full_irq_en_d;

    logic                  wr;
    logic [15:0]           div_eff;
    logic                  tick;
    logic                  full;
    logic                  unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr      = chipselect & ~write_n;
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick    = (presc_q == div_eff - 16'd1);
    assign full    = (count_q == 5'(WIDTH));

    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        div_d   = div_q;
        if (wr && address == 3'd3) begin
            div_d   = writedata[15:0];
            presc_d = 16'd0;
        end

        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == 4'(STABLE_SAMPLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end

        // Set term is ORed after the W1C mask so a same-cycle change survives the clear.
        edge_d = edge_q;
        if (wr && address == 3'd2) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | (stable_d ^ stable_q);

        irqmask_d = irqmask_q;
        if (wr && address == 3'd1) begin
            irqmask_d = writedata[WIDTH-1:0];
        end

        count_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count_d = count_d + 5'(stable_q[i]);
        end

`ifdef SENSOR_FULL_IRQ_EN
        full_irq_en_d = full_irq_en_q;
        if (wr && address == 3'd1) begin
            full_irq_en_d = writedata[16];
        end
        full_evt_d = full_evt_q;
        if (wr && address == 3'd4 && writedata[16]) begin
            full_evt_d = 1'b0;
        end
        if (count_d == 5'(WIDTH) && !full) begin
            full_evt_d = 1'b1;
        end
`else
        full_irq_en_d = 1'b0;
        full_evt_d    = 1'b0;
`endif

        irq_d = (|(edge_q & irqmask_q)) | (full_evt_q & full_irq_en_q);

        readdata_d = '0;
        case (address)
            3'd0: readdata_d[WIDTH-1:0] = stable_q;
            3'd1: begin
                readdata_d[WIDTH-1:0] = irqmask_q;
                readdata_d[16]        = full_irq_en_q;
            end
            3'd2: readdata_d[WIDTH-1:0] = edge_q;
            3'd3: readdata_d[15:0] = div_q;
            3'd4: begin
                readdata_d[4:0] = count_q;
                readdata_d[8]   = full;
                readdata_d[9]   = (count_q == 5'd0);
                readdata_d[16]  = full_evt_q;
            end
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            cnt_q         <= '0;
            edge_q        <= '0;
            irqmask_q     <= '0;
            div_q         <= DIV_RESET;
            presc_q       <= '0;
            count_q       <= '0;
            readdata_q    <= '0;
            irq_q         <= 1'b0;
            full_evt_q    <= 1'b0;
            full_irq_en_q <= 1'b0;
        end else begin
            sync1_q       <= in_port;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            edge_q        <= edge_d;
            irqmask_q     <= irqmask_d;
            div_q         <= div_d;
            presc_q       <= presc_d;
            count_q       <= count_d;
            readdata_q    <= readdata_d;
            irq_q         <= irq_d;
            full_evt_q    <= full_evt_d;
            full_irq_en_q <= full_irq_en_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_pio_sensor_scan.sv
// Directed bench for nios_pio_sensor_scan: register table plus debounce/irq/W1C/full sequences.
module tb_nios_pio_sensor_scan;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    nios_pio_sensor_scan #(
        .WIDTH(8),
        .DIV_RESET(16'd50000),
        .STABLE_SAMPLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

`ifdef SENSOR_FULL_IRQ_EN
    localparam logic [31:0] MASK_ALL = 32'h0001_00FF;
    localparam logic [31:0] MASK16   = 32'h0001_0000;
    localparam logic [31:0] FULLEVT  = 32'h0001_0000;
    localparam logic        FULLIRQ  = 1'b1;
`else
    localparam logic [31:0] MASK_ALL = 32'h0000_00FF;
    localparam logic [31:0] MASK16   = 32'h0000_0000;
    localparam logic [31:0] FULLEVT  = 32'h0000_0000;
    localparam logic        FULLIRQ  = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic apply_table(input int first, input int last);
        logic [31:0] rd;
        for (int i = first; i <= last; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
            bus_read(tbl[i].addr, rd);
            check(tbl[i].name, rd, tbl[i].exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        found;
        logic        prev_irq;
        logic        irq_seen;
        int          k;

        tbl[0]  = '{"rst_data",    1'b0, 3'd0, 32'h0,          32'h0};
        tbl[1]  = '{"rst_irqmask", 1'b0, 3'd1, 32'h0,          32'h0};
        tbl[2]  = '{"rst_edge",    1'b0, 3'd2, 32'h0,          32'h0};
        tbl[3]  = '{"rst_div",     1'b0, 3'd3, 32'h0,          32'd50000};
        tbl[4]  = '{"rst_status",  1'b0, 3'd4, 32'h0,          32'h200};
        tbl[5]  = '{"mask_all",    1'b1, 3'd1, 32'hFFFF_FFFF,  MASK_ALL};
        tbl[6]  = '{"mask_5a",     1'b1, 3'd1, 32'h0000_005A,  32'h5A};
        tbl[7]  = '{"div_trunc",   1'b1, 3'd3, 32'hABCD_1234,  32'h1234};
        tbl[8]  = '{"edge_w1c0",   1'b1, 3'd2, 32'h0000_00FF,  32'h0};
        tbl[9]  = '{"data_ro",     1'b1, 3'd0, 32'h0000_00FF,  32'h0};
        tbl[10] = '{"status_ro",   1'b1, 3'd4, 32'hFFFF_FFFF,  32'h200};
        tbl[11] = '{"addr5",       1'b1, 3'd5, 32'hFFFF_FFFF,  32'h0};
        tbl[12] = '{"addr6",       1'b1, 3'd6, 32'hFFFF_FFFF,  32'h0};
        tbl[13] = '{"addr7",       1'b1, 3'd7, 32'hFFFF_FFFF,  32'h0};
        tbl[14] = '{"mask_clr",    1'b1, 3'd1, 32'h0,          32'h0};

        clocks(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        clocks(1);
        apply_table(0, 14);

        // Debounce accept with DIV=4
        bus_write(3'd3, 32'd4);
        in_port = 8'h01;
        address = 3'd0;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (readdata[7:0] == 8'h01) break;
        end
        check("accept_latency_ok", {31'b0, (k >= 15 && k <= 21)}, 32'h1);
        bus_read(3'd2, rd);
        check("accept_edge", rd, 32'h01);
        bus_read(3'd4, rd);
        check("accept_status", rd, 32'h001);
        bus_write(3'd2, 32'h01);

        // 10-clk glitch on bit 3 spans at most 3 ticks
        in_port = 8'h09;
        clocks(10);
        in_port = 8'h01;
        clocks(30);
        bus_read(3'd0, rd);
        check("glitch_data", rd, 32'h01);
        bus_read(3'd2, rd);
        check("glitch_edge", rd, 32'h00);

        // irq path: irq samples alongside the EDGE readback, both lag edge_q by one clk
        bus_write(3'd1, 32'h04);
        in_port = 8'h05;
        address = 3'd2;
        found = 1'b0;
        prev_irq = irq;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (readdata[2]) found = 1'b1;
            else prev_irq = irq;
        end
        check("irq_edge_seen", {31'b0, found}, 32'h1);
        check("irq_before_edge", {31'b0, prev_irq}, 32'h0);
        check("irq_with_edge", {31'b0, irq}, 32'h1);
        bus_write(3'd2, 32'h04);
        check("irq_w1c_same_clk", {31'b0, irq}, 32'h1);
        clocks(1);
        check("irq_w1c_next_clk", {31'b0, irq}, 32'h0);

        in_port = 8'h01;
        clocks(30);
        check("irq_leave", {31'b0, irq}, 32'h1);
        bus_write(3'd2, 32'h04);
        clocks(2);

        in_port = 8'h03;
        address = 3'd2;
        found = 1'b0;
        irq_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            irq_seen = irq_seen | irq;
            if (readdata[1]) found = 1'b1;
        end
        check("bay1_edge", {31'b0, found}, 32'h1);
        check("bay1_irq_masked", {31'b0, irq_seen}, 32'h0);
        bus_write(3'd2, 32'h02);

        // W1C lands on the exact edge where bit 1 falls (DIV=0: accept on 6th clk)
        bus_write(3'd3, 32'd0);
        in_port = 8'h01;
        repeat (5) @(posedge clk);
        #1;
        bus_write(3'd2, 32'h02);
        bus_read(3'd2, rd);
        check("w1c_collision_edge", rd, 32'h02);
        bus_read(3'd0, rd);
        check("w1c_collision_data", rd, 32'h01);

        // All bays, tick every clk
        in_port = 8'hFF;
        address = 3'd0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (readdata[7:0] == 8'hFF) break;
        end
        check("full_data_clk", k, 7);
        bus_read(3'd4, rd);
        check("full_status", rd, 32'h108 | FULLEVT);
        bus_write(3'd1, 32'h0001_0000);
        bus_read(3'd1, rd);
        check("full_mask16", rd, MASK16);
        clocks(1);
        check("full_irq", {31'b0, irq}, {31'b0, FULLIRQ});

        in_port = 8'h00;
        clocks(10);
        bus_read(3'd2, rd);
        check("empty_edge_all", rd, 32'hFF);
        bus_read(3'd4, rd);
        check("empty_status", rd, 32'h200 | FULLEVT);
        bus_write(3'd1, 32'hFF);
        clocks(2);
        check("irq_all", {31'b0, irq}, 32'h1);

        // Mid-operation reset with sensors already high
        in_port = 8'h81;
        reset_n = 1'b0;
        #1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        clocks(3);
        reset_n = 1'b1;
        clocks(1);
        apply_table(0, 4);
        bus_write(3'd3, 32'd0);
        clocks(10);
        bus_read(3'd0, rd);
        check("post_rst_data", rd, 32'h81);
        bus_read(3'd2, rd);
        check("post_rst_edge", rd, 32'h81);
        bus_read(3'd4, rd);
        check("post_rst_status", rd, 32'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
